// File: rtl/rtc_bus_burst_engine.sv
// rtc_bus_burst_engine
// Burst sequencer for the external RTC's multiplexed AddressData bus.
// Each beat runs an address strobe, a hold, a data strobe and a hold.
// Consecutive beats are separated by an idle gap. The address
// auto-increments per beat, and an abort drops the strobes into a short
// recovery before returning to idle. Every output is registered.
module rtc_bus_burst_engine #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 5,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    output logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [LEN_W-1:0]  rd_index,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              a_d,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in
);

    // Phase timer: holds (remaining cycles - 1) of the current phase.
    localparam int T_PH_MAX = (T_PULSE > T_HOLD) ? T_PULSE : T_HOLD;
    localparam int T_MAX    = (T_PH_MAX > T_GAP) ? T_PH_MAX : T_GAP;
    localparam int TCNT_W   = $clog2(T_MAX + 1);

    localparam logic [TCNT_W-1:0] TP_LD = TCNT_W'(T_PULSE - 1);
    localparam logic [TCNT_W-1:0] TH_LD = TCNT_W'(T_HOLD - 1);
    localparam logic [TCNT_W-1:0] TG_LD = TCNT_W'((T_GAP > 0) ? T_GAP - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_AHOLD = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DHOLD = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_RECOV = 3'd6;

    logic [2:0]        state, state_nxt;
    logic [TCNT_W-1:0] tcnt, tcnt_nxt;
    logic [LEN_W-1:0]  beat, len_q;
    logic [ADDR_W-1:0] addr_q, addr_inc;
    logic              write_q;

    logic accept, len_zero, phase_end, last_beat;
    logic advance, capture, sample, done_nxt, err_nxt;

    // Next-state and phase-timer sequencing; abort overrides every busy phase.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_nxt = state;
        phase_end = (tcnt == '0);
        tcnt_nxt  = phase_end ? '0 : tcnt - TCNT_W'(1);
        accept    = 1'b0;
        len_zero  = (cmd_len == '0);
        last_beat = (beat == len_q - LEN_W'(1));
        addr_inc  = addr_q + ADDR_W'(1);

        case (state)
            S_IDLE: begin
                tcnt_nxt = '0;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (!len_zero) begin
                        state_nxt = S_ADDR;
                        tcnt_nxt  = TP_LD;
                    end
                end
            end
            S_ADDR: begin
                if (phase_end) begin
                    state_nxt = S_AHOLD;
                    tcnt_nxt  = TH_LD;
                end
            end
            S_AHOLD: begin
                if (phase_end) begin
                    state_nxt = S_DATA;
                    tcnt_nxt  = TP_LD;
                end
            end
            S_DATA: begin
                if (phase_end) begin
                    state_nxt = S_DHOLD;
                    tcnt_nxt  = TH_LD;
                end
            end
            S_DHOLD: begin
                if (phase_end) begin
                    if (last_beat) begin
                        state_nxt = S_IDLE;
                    end else if (T_GAP > 0) begin
                        state_nxt = S_GAP;
                        tcnt_nxt  = TG_LD;
                    end else begin
                        state_nxt = S_ADDR;
                        tcnt_nxt  = TP_LD;
                    end
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    state_nxt = S_ADDR;
                    tcnt_nxt  = TP_LD;
                end
            end
            S_RECOV: begin
                if (phase_end) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tcnt_nxt  = '0;
            end
        endcase

        // A second abort during recovery does not stretch it.
        if (abort && state != S_IDLE && state != S_RECOV) begin
            state_nxt = S_RECOV;
            tcnt_nxt  = TH_LD;
        end

        advance  = (state == S_DHOLD || state == S_GAP) && (state_nxt == S_ADDR);
        capture  = (state == S_DATA) && (tcnt == TP_LD) && write_q;
        sample   = (state == S_DATA) && phase_end && !write_q;
        done_nxt = (accept && len_zero) || (state != S_IDLE && state_nxt == S_IDLE);
        err_nxt  = (accept && len_zero) || (state == S_RECOV);
    end

    // State, command context and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            tcnt      <= '0;
            beat      <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_req    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_index  <= '0;
            a_d       <= 1'b0;
            cs        <= 1'b1;
            rd        <= 1'b1;
            wr        <= 1'b1;
            ad_out    <= '0;
            ad_oe     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state <= state_nxt;
            tcnt  <= tcnt_nxt;

            if (accept) begin
                write_q <= cmd_write;
                len_q   <= cmd_len;
                addr_q  <= cmd_addr;
                beat    <= '0;
            end else if (advance) begin
                addr_q <= addr_inc;
                beat   <= beat + LEN_W'(1);
            end

            // The bus shows the address from the first ADDR cycle. Write data
            // replaces it once captured, so the first DATA cycle still carries
            // the address while the data is fetched.
            if (accept) begin
                ad_out <= DATA_W'(cmd_addr);
            end else if (advance) begin
                ad_out <= DATA_W'(addr_inc);
            end else if (capture) begin
                ad_out <= wr_data;
            end

            // Bus pins are decoded from the phase being entered.
            cs    <= !(state_nxt == S_ADDR || state_nxt == S_DATA);
            wr    <= !(state_nxt == S_ADDR || (state_nxt == S_DATA && write_q));
            rd    <= !(state_nxt == S_DATA && !write_q);
            a_d   <= (state_nxt == S_DATA || state_nxt == S_DHOLD);
            ad_oe <= (state_nxt == S_ADDR || state_nxt == S_AHOLD) ||
                     ((state_nxt == S_DATA || state_nxt == S_DHOLD) && write_q);

            // Data is requested in the last address-hold cycle.
            wr_req <= (state_nxt == S_AHOLD) && (tcnt_nxt == '0) && write_q;

            // A sampled read beat is always reported, even if abort arrives with it.
            rd_valid <= sample;
            if (sample) begin
                rd_data  <= ad_in;
                rd_index <= beat;
            end

            done      <= done_nxt;
            err       <= done_nxt && err_nxt;
            cmd_ready <= (state_nxt == S_IDLE);
            busy      <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_rtc_bus_burst_engine.sv
// tb_rtc_bus_burst_engine
// Table of directed commands plus random commands. Every cycle of a command
// is checked against a cycle-offset model: the phase is derived from the
// offset since acceptance by division and remainder over the beat period.
module tb_rtc_bus_burst_engine;

    localparam int P    = 4;
    localparam int H    = 2;
    localparam int G    = 2;
    localparam int BEAT = 2 * (P + H);
    localparam int PER  = BEAT + G;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_write, abort;
    logic [7:0] cmd_addr, wr_data, ad_in;
    logic [4:0] cmd_len;
    logic       cmd_ready, wr_req, rd_valid, done, err, busy;
    logic       a_d, cs, rd, wr, ad_oe;
    logic [7:0] rd_data, ad_out;
    logic [4:0] rd_index;

    int checks = 0;
    int errors = 0;

    rtc_bus_burst_engine dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .abort(abort),
        .wr_req(wr_req), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index),
        .done(done), .err(err), .busy(busy),
        .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [4:0] len;
        int         abort_at;   // cycle offset of abort after accept, 0 = none
        int         exp_done;   // cycle offset of the done pulse
        logic       exp_err;
        int         exp_rdv;
        int         exp_wrq;
    } vec_t;

    vec_t vecs[12];

    // Runs one command from its accept cycle to its done cycle, checking every cycle.
    task automatic run_cmd(input logic w, input logic [7:0] a, input logic [4:0] len,
                           input int ta_in, output int done_at, output logic err_seen,
                           output int rdv_n, output int wrq_n);
        int         n_len, last_t, end_t, ta, u, b, r;
        logic [7:0] data [32];
        logic [7:0] ad_exp, smp_val;
        logic [4:0] smp_idx;
        logic       smp_pending, chk_ad;
        logic [10:0] exp_v, mask, act_v;

        n_len  = int'(len);
        last_t = (n_len == 0) ? 0 : n_len * BEAT + (n_len - 1) * G;
        ta     = (ta_in > last_t) ? 0 : ta_in;
        end_t  = (n_len == 0) ? 1 : ((ta != 0) ? ta + H + 1 : last_t + 1);
        for (int i = 0; i < 32; i++) data[i] = 8'($urandom);
        done_at = -1; err_seen = 1'b0; rdv_n = 0; wrq_n = 0;
        smp_pending = 1'b0; smp_val = 8'h00; smp_idx = 5'd0;

        @(negedge clk);
        check("ready_at_accept", 32'({cmd_ready, busy}), 32'b10);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = len; abort = 1'b0;
        wr_data = 8'($urandom); ad_in = 8'($urandom);

        for (int t = 1; t <= end_t; t++) begin
            @(negedge clk);
            // expected vector {cs, rd, wr, a_d, ad_oe, wr_req, rd_valid, done, err, cmd_ready, busy}
            exp_v = 11'b111_0_0_0_0_0_0_0_1;
            mask  = 11'h7FF;
            chk_ad = 1'b0; ad_exp = 8'h00;
            u = t - 1; b = u / PER; r = u % PER;
            if (t == end_t) begin
                exp_v[3] = 1'b1;
                exp_v[2] = (n_len == 0) || (ta != 0);
                exp_v[1] = 1'b1;
                exp_v[0] = 1'b0;
            end else if (ta != 0 && t > ta) begin
                mask[7] = 1'b0;
            end else if (r < P) begin
                exp_v[10] = 1'b0; exp_v[8] = 1'b0; exp_v[6] = 1'b1;
                chk_ad = 1'b1; ad_exp = a + 8'(b);
            end else if (r < P + H) begin
                exp_v[6] = 1'b1; exp_v[5] = w && (r == P + H - 1);
                chk_ad = 1'b1; ad_exp = a + 8'(b);
            end else if (r < 2 * P + H) begin
                exp_v[10] = 1'b0; exp_v[7] = 1'b1;
                if (w) begin
                    exp_v[8] = 1'b0; exp_v[6] = 1'b1;
                    chk_ad = (r > P + H); ad_exp = data[b];
                end else begin
                    exp_v[9] = 1'b0;
                end
            end else if (r < BEAT) begin
                exp_v[7] = 1'b1; exp_v[6] = w;
                chk_ad = w; ad_exp = data[b];
            end
            exp_v[4] = smp_pending;

            act_v = {cs, rd, wr, a_d, ad_oe, wr_req, rd_valid, done, err, cmd_ready, busy};
            check($sformatf("bus a=%0h len=%0d t=%0d", a, n_len, t), 32'(act_v & mask), 32'(exp_v & mask));
            if (chk_ad) check($sformatf("ad_out a=%0h t=%0d", a, t), 32'(ad_out), 32'(ad_exp));
            if (smp_pending) begin
                check($sformatf("rd_data t=%0d", t), 32'(rd_data), 32'(smp_val));
                check($sformatf("rd_index t=%0d", t), 32'(rd_index), 32'(smp_idx));
            end
            rdv_n = rdv_n + int'(rd_valid);
            wrq_n = wrq_n + int'(wr_req);
            if (done && done_at < 0) begin
                done_at  = t;
                err_seen = err;
            end

            // inputs for cycle t
            smp_pending = 1'b0;
            cmd_valid = (t < end_t) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = 8'($urandom);
            cmd_len   = 5'($urandom_range(0, 31));
            abort     = (t == ta) || (t == end_t && $urandom_range(0, 1) == 1);
            wr_data   = 8'($urandom);
            ad_in     = 8'($urandom);
            if (t < end_t && !(ta != 0 && t > ta)) begin
                if (w && r == P + H) wr_data = data[b];
                if (!w && r == 2 * P + H - 1) begin
                    smp_pending = 1'b1; smp_val = ad_in; smp_idx = 5'(b);
                end
            end
        end
    endtask

    initial begin
        int         done_at, rdv_n, wrq_n, done_cnt, last_t, ta, lim, exp_rdv, exp_wrq;
        logic       err_seen, w;
        logic [7:0] a;
        logic [4:0] len;

        reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
        cmd_len = 5'd0; abort = 1'b0; wr_data = 8'h00; ad_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({cmd_ready, busy, done, err, wr_req, rd_valid}), 32'b100000);
        check("reset_bus", 32'({cs, rd, wr, a_d, ad_oe}), 32'b11100);
        check("reset_data", 32'({ad_out, rd_data, rd_index}), 32'h0);
        reset = 1'b1;

        //          write  addr   len    abort done err  rdv wrq
        vecs[0]  = '{1'b0, 8'h05, 5'd1,  0,  13,  1'b0, 1,  0};
        vecs[1]  = '{1'b1, 8'h21, 5'd3,  0,  41,  1'b0, 0,  3};
        vecs[2]  = '{1'b0, 8'hFE, 5'd3,  0,  41,  1'b0, 3,  0};
        vecs[3]  = '{1'b1, 8'h10, 5'd0,  0,  1,   1'b1, 0,  0};
        vecs[4]  = '{1'b0, 8'h80, 5'd4,  19, 22,  1'b1, 1,  0};
        vecs[5]  = '{1'b0, 8'h33, 5'd2,  24, 27,  1'b1, 2,  0};
        vecs[6]  = '{1'b1, 8'h44, 5'd2,  26, 29,  1'b1, 0,  2};
        vecs[7]  = '{1'b1, 8'h50, 5'd1,  1,  4,   1'b1, 0,  0};
        vecs[8]  = '{1'b1, 8'h60, 5'd1,  6,  9,   1'b1, 0,  1};
        vecs[9]  = '{1'b0, 8'hF0, 5'd31, 0,  433, 1'b0, 31, 0};
        vecs[10] = '{1'b1, 8'hFF, 5'd2,  0,  27,  1'b0, 0,  2};
        vecs[11] = '{1'b0, 8'h00, 5'd1,  12, 15,  1'b1, 1,  0};

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].write, vecs[i].addr, vecs[i].len, vecs[i].abort_at,
                    done_at, err_seen, rdv_n, wrq_n);
            check($sformatf("vec%0d done_at", i), 32'(done_at), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d err", i), 32'(err_seen), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d rd_valid count", i), 32'(rdv_n), 32'(vecs[i].exp_rdv));
            check($sformatf("vec%0d wr_req count", i), 32'(wrq_n), 32'(vecs[i].exp_wrq));
        end

        // Reset asserted in the middle of a write DATA phase.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_len = 5'd1; wr_data = 8'hA5;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        check("rst_pre_in_data", 32'({cs, wr, a_d}), 32'b001);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_data", 32'({cs, wr, rd, ad_oe, cmd_ready, busy, done}), 32'b1110100);
        reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            done_cnt = done_cnt + int'(done);
        end
        check("rst_no_done", 32'(done_cnt), 32'd0);

        // Random commands with occasional aborts.
        for (int k = 0; k < 40; k++) begin
            w      = 1'($urandom_range(0, 1));
            a      = 8'($urandom);
            len    = 5'($urandom_range(0, 8));
            last_t = (len == 5'd0) ? 0 : int'(len) * BEAT + (int'(len) - 1) * G;
            ta     = (len != 5'd0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, last_t)) : 0;
            lim    = (ta == 0) ? last_t : ta;
            exp_rdv = 0; exp_wrq = 0;
            for (int bb = 0; bb < int'(len); bb++) begin
                if (!w && bb * PER + 2 * P + H <= lim) exp_rdv++;
                if (w && bb * PER + P + H <= lim) exp_wrq++;
            end
            run_cmd(w, a, len, ta, done_at, err_seen, rdv_n, wrq_n);
            check($sformatf("rnd%0d rd_valid count", k), 32'(rdv_n), 32'(exp_rdv));
            check($sformatf("rnd%0d wr_req count", k), 32'(wrq_n), 32'(exp_wrq));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
